pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage core. It sits beside the ID/EX pipeline register and drives the stall and bubble controls of PC, IF/ID, ID/EX and EX/MEM. It detects load-use hazards, squashes wrong-path instructions when EX resolves a redirect, and holds the front end while a fixed-latency FPU operation occupies EX.

## Interface
- REGFILE_LEN, 6, width of register indices (64-entry unified int/fp file)
- FPU_LATENCY, 4, cycles an FPU op occupies EX; legal range 1..2^FPU_CNT_WIDTH
- FPU_CNT_WIDTH, 3, width of the FPU occupancy counter

Ports (clock and reset first):
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REGFILE_LEN  ID source register 1
- id_rs2  in  REGFILE_LEN  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_alu_fpu  in  1  ID instruction is an FPU op
- ex_rd  in  REGFILE_LEN  ID/EX out_rd
- ex_mem_read  in  1  ID/EX out_mem_read
- ex_reg_write  in  1  ID/EX out_reg_write
- branch_taken  in  1  EX resolved a taken branch, jal or jalr this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  load NOP into IF/ID at next edge
- id_ex_stall  out  1  hold ID/EX (drives its stall input)
- id_ex_bubble  out  1  load all-zero controls into ID/EX at next edge
- ex_mem_bubble  out  1  load all-zero controls into EX/MEM at next edge
- fpu_busy  out  1  state is FPU_WAIT

## Operation
- States: RUN and FPU_WAIT. Counter cnt is FPU_CNT_WIDTH wide.
- Conditions:
  - load_use = id_valid & ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - fpu_issue = RUN & id_valid & id_alu_fpu & ~branch_taken & ~load_use.
- Priority: rst > FPU_WAIT > branch_taken > load_use > fpu_issue.
- FPU_WAIT:
  - Asserts pc_stall, if_id_stall, id_ex_stall and ex_mem_bubble. All other outputs are 0.
  - cnt decrements each cycle; cnt==1 at an edge moves to RUN.
  - branch_taken and load_use are ignored. FPU ops never redirect, so branch_taken in this state is an assertion error.
- RUN, branch_taken: if_id_flush=1 and id_ex_bubble=1. No stalls.
- RUN, load_use with no branch: pc_stall=1, if_id_stall=1, id_ex_bubble=1, id_ex_stall=0. This inserts exactly one bubble, because the bubble clears ex_mem_read.
- RUN, fpu_issue: outputs are all 0. If FPU_LATENCY>1, go to FPU_WAIT next edge with cnt=FPU_LATENCY-1. FPU_LATENCY==1 never leaves RUN.
- Register 0 never produces a hazard.

## Timing
- All outputs are combinational (Mealy) from state, cnt and inputs. fpu_busy is a pure state decode.
- Reset values: state=RUN, cnt=0. While rst is high, all outputs are 0.
- Reset mid-FPU_WAIT aborts the wait immediately, asynchronously.
- Load-use costs 1 cycle. Branch flush costs 2 squashed slots and 0 stall cycles. An FPU op costs FPU_LATENCY-1 stall cycles.
- FPU op in ID in cycle N occupies EX in cycles N+1..N+FPU_LATENCY. fpu_busy is high in N+1..N+FPU_LATENCY-1.
- load_use and branch_taken in the same cycle: branch wins. No stall; only the flush is applied.

## Configuration
- PIPE_HAZARD_PERF_EN defined adds three outputs:
  - stall_cycles (32): +1 per cycle with pc_stall=1.
  - flush_count (32): +1 per cycle with if_id_flush=1.
  - perf_clr (1, input): synchronous clear.
- Both counters reset to 0 and wrap at 2^32.
- PIPE_HAZARD_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1; next cycle (ex_mem_read=0) all outputs 0.
- Load-use on ex_rd=0, or id_uses_rs1=0 -> no stall.
- branch_taken=1 together with a matching load_use -> if_id_flush=id_ex_bubble=1, pc_stall=0.
- FPU_LATENCY=4, fpu_issue at cycle N:
  - fpu_busy, id_ex_stall and ex_mem_bubble are high exactly in cycles N+1..N+3.
  - RUN at N+4.
- FPU_LATENCY=1 -> fpu_issue produces no stall and fpu_busy stays 0.
- rst asserted at cnt=2 in FPU_WAIT -> outputs 0 immediately; after release, state=RUN, cnt=0.
- PIPE_HAZARD_PERF_EN: run the FPU scenario plus one branch -> stall_cycles=3, flush_count=1; perf_clr zeroes both.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the five-stage core: load-use, redirect squash and FPU occupancy.
// Optional performance counters are enabled with `define PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int REGFILE_LEN   = 6,
    parameter int FPU_LATENCY   = 4,
    parameter int FPU_CNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REGFILE_LEN-1:0] id_rs1,
    input  logic [REGFILE_LEN-1:0] id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   id_alu_fpu,
    input  logic [REGFILE_LEN-1:0] ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_reg_write,
    input  logic                   branch_taken,
`ifdef PIPE_HAZARD_PERF_EN
    input  logic                   perf_clr,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            flush_count,
`endif
    output logic                   pc_stall,
    output logic                   if_id_stall,
    output logic                   if_id_flush,
    output logic                   id_ex_stall,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_bubble,
    output logic                   fpu_busy
);

    typedef enum logic {RUN, FPU_WAIT} state_t;

    localparam logic [FPU_CNT_WIDTH-1:0] CNT_INIT = FPU_CNT_WIDTH'(FPU_LATENCY - 1);
    localparam logic [FPU_CNT_WIDTH-1:0] CNT_ONE  = FPU_CNT_WIDTH'(1);

    state_t                   state, state_next;
    logic [FPU_CNT_WIDTH-1:0] cnt, cnt_next;
    logic                     load_use;
    logic                     fpu_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        load_use = id_valid & ex_mem_read & ex_reg_write & (ex_rd != '0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
        fpu_issue = (state == RUN) & id_valid & id_alu_fpu & ~branch_taken & ~load_use;

        state_next    = state;
        cnt_next      = cnt;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        fpu_busy      = (state == FPU_WAIT);

        case (state)
            FPU_WAIT: begin
                // Front end frozen; EX/MEM gets bubbles while the FPU op holds EX.
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_bubble = 1'b1;
                cnt_next      = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_next = RUN;
                end
            end
            default: begin
                if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    // One bubble suffices: it clears ex_mem_read for the next compare.
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (fpu_issue && (FPU_LATENCY > 1)) begin
                    state_next = FPU_WAIT;
                    cnt_next   = CNT_INIT;
                end
            end
        endcase

        if (rst) begin
            pc_stall      = 1'b0;
            if_id_stall   = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_stall   = 1'b0;
            id_ex_bubble  = 1'b0;
            ex_mem_bubble = 1'b0;
            fpu_busy      = 1'b0;
        end
    end

    // FPU ops never redirect, so a redirect while waiting means an upstream bug.
    no_branch_in_fpu_wait: assert property (@(posedge clk) disable iff (rst)
        (state == FPU_WAIT) |-> !branch_taken);

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (if_id_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FPU_LATENCY=4 main instance, FPU_LATENCY=1 side instance).
// Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble, fpu_busy}.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_alu_fpu;
    logic [5:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read, ex_reg_write, branch_taken;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble, fpu_busy;
    logic       pc_stall1, if_id_stall1, if_id_flush1, id_ex_stall1, id_ex_bubble1, ex_mem_bubble1, fpu_busy1;
    logic [6:0] outs, outs1;
`ifdef PIPE_HAZARD_PERF_EN
    logic        perf_clr;
    logic [31:0] stall_cycles, flush_count, stall_cycles1, flush_count1;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] LUSE  = 7'b1100100;
    localparam logic [6:0] FLUSH = 7'b0010100;
    localparam logic [6:0] FWAIT = 7'b1101011;

    always #5 clk = ~clk;

    assign outs  = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble, fpu_busy};
    assign outs1 = {pc_stall1, if_id_stall1, if_id_flush1, id_ex_stall1, id_ex_bubble1, ex_mem_bubble1, fpu_busy1};

    pipeline_hazard_ctrl #(.REGFILE_LEN(6), .FPU_LATENCY(4), .FPU_CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_alu_fpu(id_alu_fpu),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .branch_taken(branch_taken),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_clr(perf_clr), .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
        .fpu_busy(fpu_busy)
    );

    pipeline_hazard_ctrl #(.REGFILE_LEN(6), .FPU_LATENCY(1), .FPU_CNT_WIDTH(3)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_alu_fpu(id_alu_fpu),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .branch_taken(branch_taken),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_clr(perf_clr), .stall_cycles(stall_cycles1), .flush_count(flush_count1),
`endif
        .pc_stall(pc_stall1), .if_id_stall(if_id_stall1), .if_id_flush(if_id_flush1),
        .id_ex_stall(id_ex_stall1), .id_ex_bubble(id_ex_bubble1), .ex_mem_bubble(ex_mem_bubble1),
        .fpu_busy(fpu_busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_alu_fpu = 0; ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0; branch_taken = 0;
    endtask

    task automatic load_use_inputs(input logic [5:0] rd);
        idle_inputs();
        id_valid = 1; id_rs1 = rd; id_uses_rs1 = 1;
        ex_rd = rd; ex_mem_read = 1; ex_reg_write = 1;
    endtask

    task automatic fpu_inputs();
        idle_inputs();
        id_valid = 1; id_alu_fpu = 1; id_rs1 = 6'd3; id_uses_rs1 = 1;
    endtask

    // Advance one cycle; inputs are changed on the falling edge and sampled 2 time units later.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        idle_inputs();
`ifdef PIPE_HAZARD_PERF_EN
        perf_clr = 0;
`endif
        @(negedge clk);
        load_use_inputs(6'd5);
        #2 chk("reset_outs_gated", 32'(outs), 32'(IDLE));
        idle_inputs();
        next_cycle();
        rst = 0;
        #2 chk("reset_cnt", 32'(dut.cnt), 32'd0);
        chk("after_reset_idle", 32'(outs), 32'(IDLE));

        next_cycle();
        load_use_inputs(6'd5);
        #2 chk("load_use_rs1", 32'(outs), 32'(LUSE));
        next_cycle();
        ex_mem_read = 0;
        #2 chk("load_use_released", 32'(outs), 32'(IDLE));

        next_cycle();
        load_use_inputs(6'd7);
        id_uses_rs1 = 0; id_rs1 = 6'd2; id_rs2 = 6'd7; id_uses_rs2 = 1;
        #2 chk("load_use_rs2", 32'(outs), 32'(LUSE));

        next_cycle();
        load_use_inputs(6'd0);
        #2 chk("load_use_x0", 32'(outs), 32'(IDLE));
        load_use_inputs(6'd5);
        id_uses_rs1 = 0;
        #2 chk("load_use_rs1_unused", 32'(outs), 32'(IDLE));
        load_use_inputs(6'd5);
        ex_reg_write = 0;
        #2 chk("load_use_no_regwrite", 32'(outs), 32'(IDLE));
        load_use_inputs(6'd5);
        id_valid = 0;
        #2 chk("load_use_id_invalid", 32'(outs), 32'(IDLE));

        load_use_inputs(6'd5);
        branch_taken = 1;
        #2 chk("branch_beats_load_use", 32'(outs), 32'(FLUSH));
        next_cycle();
        idle_inputs();
        branch_taken = 1;
        #2 chk("branch_alone", 32'(outs), 32'(FLUSH));

        // FPU op together with a branch is squashed, not issued.
        next_cycle();
        fpu_inputs();
        branch_taken = 1;
        #2 chk("fpu_with_branch", 32'(outs), 32'(FLUSH));
        next_cycle();
        idle_inputs();
        #2 chk("fpu_with_branch_next", 32'(outs), 32'(IDLE));

        // FPU op behind a load-use waits for the stall, not the FPU.
        fpu_inputs();
        ex_rd = 6'd3; ex_mem_read = 1; ex_reg_write = 1;
        #2 chk("fpu_blocked_by_load_use", 32'(outs), 32'(LUSE));
        next_cycle();
        idle_inputs();
        #2 chk("fpu_blocked_next", 32'(outs), 32'(IDLE));

        // FPU issue at cycle N.
        fpu_inputs();
        #2 chk("fpu_issue_N", 32'(outs), 32'(IDLE));
        chk("lat1_issue_N", 32'(outs1), 32'(IDLE));
        next_cycle();
        idle_inputs();
        #2 chk("fpu_N+1", 32'(outs), 32'(FWAIT));
        chk("fpu_N+1_cnt", 32'(dut.cnt), 32'd3);
        chk("lat1_N+1", 32'(outs1), 32'(IDLE));
        next_cycle();
        load_use_inputs(6'd9);
        #2 chk("fpu_N+2_ignores_load_use", 32'(outs), 32'(FWAIT));
        next_cycle();
        idle_inputs();
        #2 chk("fpu_N+3", 32'(outs), 32'(FWAIT));
        next_cycle();
        #2 chk("fpu_N+4_run", 32'(outs), 32'(IDLE));
        chk("fpu_N+4_cnt", 32'(dut.cnt), 32'd0);

        // Reset arrives while cnt==2 in FPU_WAIT.
        next_cycle();
        fpu_inputs();
        next_cycle();
        idle_inputs();
        next_cycle();
        #2 chk("pre_reset_cnt", 32'(dut.cnt), 32'd2);
        chk("pre_reset_wait", 32'(outs), 32'(FWAIT));
        #1 rst = 1;
        #1 chk("mid_wait_reset_outs", 32'(outs), 32'(IDLE));
        chk("mid_wait_reset_cnt", 32'(dut.cnt), 32'd0);
        next_cycle();
        rst = 0;
        #2 chk("post_reset_outs", 32'(outs), 32'(IDLE));
        next_cycle();
        #2 chk("post_reset_still_run", 32'(outs), 32'(IDLE));
        chk("post_reset_cnt", 32'(dut.cnt), 32'd0);

`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_stall_reset", stall_cycles, 32'd0);
        chk("perf_flush_reset", flush_count, 32'd0);
        fpu_inputs();
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
        next_cycle();
        branch_taken = 1;
        next_cycle();
        branch_taken = 0;
        #2 chk("perf_stall_cycles", stall_cycles, 32'd3);
        chk("perf_flush_count", flush_count, 32'd1);
        perf_clr = 1;
        next_cycle();
        perf_clr = 0;
        #2 chk("perf_clr_stall", stall_cycles, 32'd0);
        chk("perf_clr_flush", flush_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
